// File: rtl/nibble_serial_loader.sv
// Serial-to-nibble front end: receives start + 4 data bits (LSB first) + stop
// and presents each good nibble with a one-cycle load strobe.
module nibble_serial_loader #(
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
    input  logic       clk,
    input  logic       rest,
    input  logic       rx_in,
    output logic [3:0] nibble_out,
    output logic       load_en,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    localparam logic [CNT_W-1:0] LAST      = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    state_t             state, state_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [1:0]         idx, idx_n;
    logic [3:0]         sr, sr_n;
    logic               sync1, rx_s;
    logic               load_n, err_n;

    // Synchronizer resets to the idle level so reset release cannot fake a start bit.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        sr_n    = sr;
        load_n  = 1'b0;
        err_n   = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_n = START;
                    cnt_n   = '0;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_n = '0;
                    if (!rx_s) begin
                        state_n = DATA;
                        idx_n   = 2'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == LAST) begin
                    cnt_n = '0;
                    sr_n  = {rx_s, sr[3:1]};
                    idx_n = idx + 2'd1;
                    if (idx == 2'd3) state_n = STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (cnt == LAST) begin
                    cnt_n   = '0;
                    state_n = IDLE;
                    if (rx_s) load_n = 1'b1;
                    else      err_n  = 1'b1;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // load_en is a fire-and-forget strobe: nibble_out is valid in the same
    // cycle load_en is high and there is no ready/back-pressure path.
    always_ff @(posedge clk or negedge rest) begin
        if (!rest) begin
            state      <= IDLE;
            cnt        <= '0;
            idx        <= 2'd0;
            sr         <= 4'h0;
            nibble_out <= 4'h0;
            load_en    <= 1'b0;
            frame_err  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            sr        <= sr_n;
            load_en   <= load_n;
            frame_err <= err_n;
            busy      <= (state_n != IDLE);
            if (load_n) nibble_out <= sr_n;
        end
    end

endmodule

// File: tb/tb_nibble_serial_loader.sv
// Scoreboard bench for nibble_serial_loader: driver pushes expected strobes,
// a negedge monitor pops and compares kind, nibble and arrival cycle.
module tb_nibble_serial_loader;

    localparam int CPB = 4;
    localparam int LAT = 25;  // rx_in start edge to strobe: 2 sync + 2 + 5*CPB + 1
    localparam int W   = 37;  // {err, nibble[3:0], cycle[31:0]}

    logic       clk = 1'b0;
    logic       rest = 1'b0;
    logic       rx_in = 1'b1;
    logic [3:0] nibble_out;
    logic       load_en, frame_err, busy;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    logic [3:0] last_good = 4'h0;
    logic [W-1:0] exp_q[$];

    nibble_serial_loader #(.CLKS_PER_BIT(CPB)) dut (
        .clk(clk), .rest(rest), .rx_in(rx_in),
        .nibble_out(nibble_out), .load_en(load_en),
        .frame_err(frame_err), .busy(busy)
    );

    // clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // driver tasks: all calls start and end at posedge + 1
    task automatic drive_bit(input logic b);
        rx_in = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic stop);
        logic [3:0] exp_nib;
        if (stop) last_good = d;
        exp_nib = last_good;
        exp_q.push_back({~stop, exp_nib, 32'(cyc + LAT)});
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(d[i]);
        drive_bit(stop);
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (rest && (load_en || frame_err)) begin
            check("pulse_exclusive", {31'd0, load_en & frame_err}, 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, load_en, frame_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", {31'd0, frame_err}, {31'd0, e[36]});
                check("nibble_out", {28'd0, nibble_out}, {28'd0, e[35:32]});
                check("pulse_cycle", 32'(cyc), e[31:0]);
            end
        end
    end

    initial begin
        int busy_cnt;
        // reset release, idle line for 50 cycles
        repeat (3) @(posedge clk);
        #2 rest = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (busy || load_en || frame_err) busy_cnt++;
        end
        check("idle_activity", 32'(busy_cnt), 32'd0);
        check("rst_nibble", {28'd0, nibble_out}, 32'h0);
        check("rst_load_en", {31'd0, load_en}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // good frame 1,0,1,1 -> 4'hD, then same frame with bad stop bit
        send_frame(4'hD, 1'b1);
        drive_bit(1'b1);
        send_frame(4'hD, 1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);

        // single-cycle low glitch must be rejected in START
        rx_in = 1'b0;
        @(posedge clk); #1;
        rx_in = 1'b1;
        busy_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
        end
        check("glitch_busy_max", {31'd0, busy_cnt <= CPB / 2}, 32'd1);
        check("glitch_busy_seen", {31'd0, busy_cnt > 0}, 32'd1);
        @(posedge clk); #1;

        // back-to-back frames, no idle gap
        send_frame(4'h3, 1'b1);
        send_frame(4'hA, 1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);

        // reset during data bit 2 of a 4'h9 frame
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b0);
        rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #2 rest = 1'b0;
        #1;
        check("midrst_nibble", {28'd0, nibble_out}, 32'h0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_load_en", {31'd0, load_en}, 32'd0);
        check("midrst_frame_err", {31'd0, frame_err}, 32'd0);
        last_good = 4'h0;
        repeat (3) @(posedge clk);
        rx_in = 1'b1;
        #2 rest = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        send_frame(4'h5, 1'b1);
        drive_bit(1'b1);

        // drain scoreboard with a bounded wait
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(posedge clk);
        repeat (4) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("final_nibble", {28'd0, nibble_out}, 32'h5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
